// File: rtl/mod_reduce_serial.sv
// Limb-serial final reduction: r = (s + 2c) mod m with a one-limb-per-cycle carry/borrow chain.
// Latency NLIMB+1 cycles; holds the result in DONE until out_ready; optional 2m subtractor via MODRED_DOUBLE_SUB_EN.
module mod_reduce_serial #(
  parameter int W    = 3072,
  parameter int LIMB = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W+1:0]   s,
  input  logic [W+1:0]   c,
  input  logic [W-1:0]   m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   r,
  output logic [1:0]     out_sub
);

  localparam int NLIMB = (W + 3 + LIMB - 1) / LIMB;
  localparam int TOT   = NLIMB * LIMB;
  localparam int KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam int LW1   = LIMB + 1;

  typedef enum logic [1:0] {IDLE, RUN, SEL, DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k;
  logic [TOT-1:0]  sh_s, sh_c2, sh_m;
  logic [W-1:0]    acc_x, acc_d1;
  logic            cy, b1;
  logic [LIMB:0]   x_sum, d1_dif;
`ifdef MODRED_DOUBLE_SUB_EN
  logic [TOT-1:0]  sh_m2;
  logic [W-1:0]    acc_d2;
  logic            b2;
  logic [LIMB:0]   d2_dif;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (k == KW'(NLIMB - 1)) state_nxt = SEL;
      SEL:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Per-limb adder and subtractors; the top bit of each result is the carry/borrow out.
  always_comb begin
    x_sum  = {1'b0, sh_s[LIMB-1:0]} + {1'b0, sh_c2[LIMB-1:0]} + LW1'(cy);
    d1_dif = {1'b0, x_sum[LIMB-1:0]} - {1'b0, sh_m[LIMB-1:0]} - LW1'(b1);
`ifdef MODRED_DOUBLE_SUB_EN
    d2_dif = {1'b0, x_sum[LIMB-1:0]} - {1'b0, sh_m2[LIMB-1:0]} - LW1'(b2);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      sh_s    <= '0;
      sh_c2   <= '0;
      sh_m    <= '0;
      acc_x   <= '0;
      acc_d1  <= '0;
      cy      <= 1'b0;
      b1      <= 1'b0;
      r       <= '0;
      out_sub <= 2'd0;
`ifdef MODRED_DOUBLE_SUB_EN
      sh_m2   <= '0;
      acc_d2  <= '0;
      b2      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh_s  <= TOT'(s);
          sh_c2 <= TOT'({c, 1'b0});
          sh_m  <= TOT'(m);
          cy    <= 1'b0;
          b1    <= 1'b0;
          k     <= '0;
`ifdef MODRED_DOUBLE_SUB_EN
          sh_m2 <= TOT'({m, 1'b0});
          b2    <= 1'b0;
`endif
        end
        RUN: begin
          sh_s  <= sh_s >> LIMB;
          sh_c2 <= sh_c2 >> LIMB;
          sh_m  <= sh_m >> LIMB;
          cy    <= x_sum[LIMB];
          b1    <= d1_dif[LIMB];
          // Only bits below W are kept; padding limbs exist solely to carry the chains.
          for (int i = 0; i < W; i++) begin
            if (k == KW'(i / LIMB)) begin
              acc_x[i]  <= x_sum[i % LIMB];
              acc_d1[i] <= d1_dif[i % LIMB];
`ifdef MODRED_DOUBLE_SUB_EN
              acc_d2[i] <= d2_dif[i % LIMB];
`endif
            end
          end
`ifdef MODRED_DOUBLE_SUB_EN
          sh_m2 <= sh_m2 >> LIMB;
          b2    <= d2_dif[LIMB];
`endif
          k <= (k == KW'(NLIMB - 1)) ? '0 : k + KW'(1);
        end
        SEL: begin
          if (b1) begin
            r       <= acc_x;
            out_sub <= 2'd0;
`ifdef MODRED_DOUBLE_SUB_EN
          end else if (!b2) begin
            r       <= acc_d2;
            out_sub <= 2'd2;
`endif
          end else begin
            r       <= acc_d1;
            out_sub <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_serial.sv
// Directed bench: small W=8/LIMB=4 instance for the arithmetic and handshake cases, default-size instance for long chains.
module tb_mod_reduce_serial;

  localparam int BW = 3072;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic       s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [9:0] s_s = '0, s_c = '0;
  logic [7:0] s_m = '0, s_r;
  logic [1:0] s_sub;

  // Default-size instance
  logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [BW+1:0] b_s = '0, b_c = '0;
  logic [BW-1:0] b_m = '0, b_r;
  logic [1:0]    b_sub;

  mod_reduce_serial #(.W(8), .LIMB(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .s(s_s), .c(s_c), .m(s_m), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .r(s_r), .out_sub(s_sub)
  );

  mod_reduce_serial u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .s(b_s), .c(b_c), .m(b_m), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .r(b_r), .out_sub(b_sub)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_small_out(input string tag, input int exp_lat);
    int n = 0;
    while (!s_out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic small_op(input string tag, input logic [9:0] sv, input logic [9:0] cv,
                          input logic [7:0] mv, input logic [7:0] er, input logic [1:0] es);
    int n = 0;
    while (!s_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 64'(s_in_ready), 64'd1);
    s_s = sv; s_c = cv; s_m = mv; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    wait_small_out(tag, 4);
    check({tag, "_r"}, 64'(s_r), 64'(er));
    check({tag, "_sub"}, 64'(s_sub), 64'(es));
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(s_out_valid), 64'd0);
    check({tag, "_rdy_rise"}, 64'(s_in_ready), 64'd1);
  endtask

  task automatic big_op(input string tag, input logic [BW+1:0] sv, input logic [BW+1:0] cv,
                        input logic [BW-1:0] mv, input logic [63:0] er_lo, input logic [1:0] es);
    int n = 0;
    b_s = sv; b_c = cv; b_m = mv; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    while (!b_out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd26);
    check({tag, "_r_lo"}, b_r[63:0], er_lo);
    check({tag, "_r_hi_zero"}, 64'(|b_r[BW-1:64]), 64'd0);
    check({tag, "_sub"}, 64'(b_sub), 64'(es));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({tag, "_rdy_rise"}, 64'(b_in_ready), 64'd1);
  endtask

  initial begin
    logic [BW-1:0] ones;
    ones = '1;

    // Reset state, observed while reset is held and after release
    #12;
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_r", 64'(s_r), 64'd0);
    check("rst_sub", 64'(s_sub), 64'd0);
    check("rst_in_ready", 64'(s_in_ready), 64'd1);
    check("rst_big_vld", 64'(b_out_valid), 64'd0);
    check("rst_big_rdy", 64'(b_in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // X = 250, m = 200 -> one subtraction
    small_op("t1", 10'd150, 10'd50, 8'd200, 8'd50, 2'd1);
    // X = 180 < m -> passthrough
    small_op("t2", 10'd100, 10'd40, 8'd200, 8'd180, 2'd0);
    // X == m -> zero
    small_op("t3", 10'd200, 10'd0, 8'd200, 8'd0, 2'd1);
    // X = 2m-1 -> m-1
    small_op("t4", 10'd399, 10'd0, 8'd200, 8'd199, 2'd1);
    // X = 290, m = 100
`ifdef MODRED_DOUBLE_SUB_EN
    small_op("t5", 10'd250, 10'd20, 8'd100, 8'd90, 2'd2);
`else
    small_op("t5", 10'd250, 10'd20, 8'd100, 8'd190, 2'd1);
`endif

    // Default size: s = 2^3072-1, c = 1 -> X = 2^3072+1, m = 2^3072-1, X-m = 2; full carry and borrow ripple
    big_op("big1", {2'b00, ones}, (BW+2)'(1), ones, 64'd2, 2'd1);
    // X = m + 2^3072 = 2m + 1: reduced only when the 2m path exists, else X-m truncates to 0
`ifdef MODRED_DOUBLE_SUB_EN
    big_op("big2", {2'b00, ones}, (BW+2)'(1) << (BW-1), ones, 64'd1, 2'd2);
`else
    big_op("big2", {2'b00, ones}, (BW+2)'(1) << (BW-1), ones, 64'd0, 2'd1);
`endif

    // Backpressure with a second operand waiting
    s_s = 10'd150; s_c = 10'd50; s_m = 8'd200; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_s = 10'd100; s_c = 10'd40;
    wait_small_out("bp_a", 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready_low", 64'(s_in_ready), 64'd0);
      check("bp_r_stable", 64'(s_r), 64'd50);
      check("bp_vld_held", 64'(s_out_valid), 64'd1);
    end
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("bp_rdy_after_pulse", 64'(s_in_ready), 64'd1);
    check("bp_vld_after_pulse", 64'(s_out_valid), 64'd0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("bp_second_accepted", 64'(s_in_ready), 64'd0);
    wait_small_out("bp_b", 4);
    check("bp_b_r", 64'(s_r), 64'd180);
    check("bp_b_sub", 64'(s_sub), 64'd0);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;

    // Reset while limb 1 is pending; r still holds 180 from the previous result
    s_s = 10'd150; s_c = 10'd50; s_m = 8'd200; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(s_out_valid), 64'd0);
    check("mid_rst_r", 64'(s_r), 64'd0);
    check("mid_rst_sub", 64'(s_sub), 64'd0);
    check("mid_rst_rdy", 64'(s_in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    small_op("post_rst", 10'd150, 10'd50, 8'd200, 8'd50, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
